// File: rtl/sonar_pkg.sv
// Shared types for the sonar sweep sequencer: FSM state codes, sweep direction
// and sweep mode constants.
package sonar_pkg;

  typedef enum logic [2:0] {
    INICIAL        = 3'd0,
    POSICIONA      = 3'd1,
    MEDE           = 3'd2,
    AGUARDA_MEDIDA = 3'd3,
    TRANSMITE      = 3'd4,
    AGUARDA_ENVIO  = 3'd5,
    PROXIMA        = 3'd6,
    ESPERA         = 3'd7
  } estado_t;

  typedef enum logic {
    SOBE  = 1'b0,
    DESCE = 1'b1
  } direcao_t;

  localparam logic MODO_CIRCULAR = 1'b0;
  localparam logic MODO_VAIVEM   = 1'b1;

endpackage

// File: rtl/sonar_varredura_posicao.sv
// Servo position index and sweep direction; steps once per avanca_i pulse,
// either wrapping or bouncing at the ends, and flags the end of a sweep.
module sonar_varredura_posicao
  import sonar_pkg::*;
#(
  parameter int N_POS = 8,
  parameter int POS_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             avanca_i,
  input  logic             modo_i,
  output logic [POS_W-1:0] posicao_o,
  output logic             fim_o
);

  localparam logic [POS_W-1:0] ULTIMA    = POS_W'(N_POS - 1);
  localparam logic [POS_W-1:0] PENULTIMA = (N_POS >= 2) ? POS_W'(N_POS - 2) : '0;
  localparam logic [POS_W-1:0] SEGUNDA   = (N_POS >= 2) ? POS_W'(1) : '0;

  logic [POS_W-1:0] pos_q, pos_d;
  direcao_t         dir_q, dir_d;
  logic             fim;

  always_comb begin
    pos_d = pos_q;
    dir_d = dir_q;
    fim   = 1'b0;
    if (avanca_i) begin
      if (N_POS == 1) begin
        // A single position is a complete sweep on every step.
        pos_d = '0;
        dir_d = SOBE;
        fim   = 1'b1;
      end else if (modo_i == MODO_CIRCULAR) begin
        dir_d = SOBE;
        if (pos_q >= ULTIMA) begin
          pos_d = '0;
          fim   = 1'b1;
        end else begin
          pos_d = pos_q + 1'b1;
        end
      end else if (dir_q == SOBE) begin
        if (pos_q >= ULTIMA) begin
          pos_d = PENULTIMA;
          dir_d = DESCE;
          fim   = 1'b1;
        end else begin
          pos_d = pos_q + 1'b1;
        end
      end else begin
        if (pos_q == '0) begin
          pos_d = SEGUNDA;
          dir_d = SOBE;
          fim   = 1'b1;
        end else begin
          pos_d = pos_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pos_q <= '0;
      dir_q <= SOBE;
    end else begin
      pos_q <= pos_d;
      dir_q <= dir_d;
    end
  end

  assign posicao_o = pos_q;
  assign fim_o     = fim;

endmodule

// File: rtl/sonar_varredura.sv
// Sweep sequencer: positions the servo, waits for it to settle, handshakes one
// measurement and one transmission with the datapath, then steps to the next position.
module sonar_varredura
  import sonar_pkg::*;
#(
  parameter int N_POS      = 8,
  parameter int POS_W      = 3,
  parameter int CNT_W      = 27,
  parameter int T_ASSENTAR = 25000000,
  parameter int T_PERIODO  = 100000000,
  parameter int T_TIMEOUT  = 5000000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ligar,
  input  logic             modo,
  input  logic             medida_pronto,
  input  logic             envio_pronto,
  output logic             medir,
  output logic             transmitir,
  output logic [POS_W-1:0] posicao,
  output logic             pronto,
  output logic             fim_varredura,
  output logic             timeout,
  output logic [3:0]       db_estado
);

  localparam logic [CNT_W-1:0] FIM_ASSENTAR = CNT_W'(T_ASSENTAR - 1);
  localparam logic [CNT_W-1:0] FIM_PERIODO  = CNT_W'(T_PERIODO - 1);
  localparam logic [CNT_W-1:0] FIM_TIMEOUT  = CNT_W'(T_TIMEOUT - 1);

  estado_t          estado_q, estado_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expirou_q, expirou_d;

  always_comb begin
    estado_d  = estado_q;
    cnt_d     = cnt_q;
    expirou_d = expirou_q;
    unique case (estado_q)
      INICIAL: begin
        cnt_d     = '0;
        expirou_d = 1'b0;
        if (ligar) estado_d = POSICIONA;
      end
      POSICIONA: begin
        if (cnt_q == FIM_ASSENTAR) begin
          cnt_d    = '0;
          estado_d = MEDE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      MEDE: begin
        cnt_d    = '0;
        estado_d = AGUARDA_MEDIDA;
      end
      AGUARDA_MEDIDA: begin
        // A measurement arriving on the last allowed cycle still counts.
        if (medida_pronto) begin
          cnt_d    = '0;
          estado_d = TRANSMITE;
        end else if (cnt_q == FIM_TIMEOUT) begin
          cnt_d     = '0;
          expirou_d = 1'b1;
          estado_d  = PROXIMA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TRANSMITE: begin
        estado_d = AGUARDA_ENVIO;
      end
      AGUARDA_ENVIO: begin
        if (envio_pronto) estado_d = PROXIMA;
      end
      PROXIMA: begin
        // ligar is only honoured here, so a started position always completes.
        cnt_d     = '0;
        expirou_d = 1'b0;
        estado_d  = ligar ? ESPERA : INICIAL;
      end
      ESPERA: begin
        if (!ligar) begin
          cnt_d    = '0;
          estado_d = INICIAL;
        end else if (cnt_q == FIM_PERIODO) begin
          cnt_d    = '0;
          estado_d = POSICIONA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d    = '0;
        estado_d = INICIAL;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q  <= INICIAL;
      cnt_q     <= '0;
      expirou_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      cnt_q     <= cnt_d;
      expirou_q <= expirou_d;
    end
  end

  sonar_varredura_posicao #(
    .N_POS (N_POS),
    .POS_W (POS_W)
  ) u_posicao (
    .clk_i     (clock),
    .rst_ni    (reset),
    .avanca_i  (estado_q == PROXIMA),
    .modo_i    (modo),
    .posicao_o (posicao),
    .fim_o     (fim_varredura)
  );

  assign medir      = (estado_q == MEDE);
  assign transmitir = (estado_q == TRANSMITE);
  assign pronto     = (estado_q == PROXIMA);
  assign timeout    = (estado_q == PROXIMA) && expirou_q;
  assign db_estado  = {1'b0, estado_q};

endmodule

// File: tb/tb_sonar_varredura.sv
// Scoreboard bench for sonar_varredura: stimulus queues the expected per-position
// results, a monitor checks them at every pronto pulse.
module tb_sonar_varredura;

  localparam int N_POS = 4;
  localparam int POS_W = 2;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             ligar = 1'b0;
  logic             modo = 1'b0;
  logic             medida_pronto = 1'b0;
  logic             envio_pronto = 1'b0;
  logic             medir, transmitir, pronto, fim_varredura, timeout;
  logic [POS_W-1:0] posicao;
  logic [3:0]       db_estado;

  sonar_varredura #(
    .N_POS      (N_POS),
    .POS_W      (POS_W),
    .CNT_W      (8),
    .T_ASSENTAR (3),
    .T_PERIODO  (5),
    .T_TIMEOUT  (10)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .ligar         (ligar),
    .modo          (modo),
    .medida_pronto (medida_pronto),
    .envio_pronto  (envio_pronto),
    .medir         (medir),
    .transmitir    (transmitir),
    .posicao       (posicao),
    .pronto        (pronto),
    .fim_varredura (fim_varredura),
    .timeout       (timeout),
    .db_estado     (db_estado)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [POS_W-1:0] pos;
    logic             fim;
    logic             to;
  } rec_t;

  rec_t exp_q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   med_d = 2;
  int   env_d = 4;
  int   exp_aguarda = 2;
  bit   tx_proibido = 1'b0;
  int   n_pronto = 0;
  int   n_medir = 0;
  int   n_tx = 0;

  task automatic check(input string nome, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nome, act, req);
    end
  endtask

  task automatic fail(input string nome);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event occurred, expected none", nome);
  endtask

  task automatic push(input int p, input bit f, input bit t);
    rec_t r;
    r.pos = POS_W'(p);
    r.fim = f;
    r.to  = t;
    exp_q.push_back(r);
  endtask

  task automatic wait_estado(input int s, input int budget, input string nome);
    int k = 0;
    while (db_estado !== 4'(s) && k < budget) begin
      @(negedge clock);
      k++;
    end
    if (db_estado !== 4'(s)) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: state %0d, expected %0d within %0d cycles", nome, db_estado, s, budget);
    end
  endtask

  task automatic wait_prontos(input int alvo, input int budget, input string nome);
    int k = 0;
    while (n_pronto < alvo && k < budget) begin
      @(negedge clock);
      #1;
      k++;
    end
    if (n_pronto < alvo) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: %0d pronto pulses, expected %0d", nome, n_pronto, alvo);
    end
  endtask

  // Datapath model: answers medir and transmitir after programmable delays.
  initial begin
    int d;
    forever begin
      @(negedge clock);
      if (reset && medir && med_d >= 0) begin
        d = med_d;
        repeat (d) @(negedge clock);
        medida_pronto = 1'b1;
        @(negedge clock);
        medida_pronto = 1'b0;
      end
    end
  end

  initial begin
    int d;
    forever begin
      @(negedge clock);
      if (reset && transmitir) begin
        d = env_d;
        repeat (d) @(negedge clock);
        envio_pronto = 1'b1;
        @(negedge clock);
        envio_pronto = 1'b0;
      end
    end
  end

  // Monitor: scoreboard on pronto, plus state dwell-time checks.
  initial begin
    int   prev;
    int   run;
    rec_t e;
    prev = 0;
    run  = 0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        prev = 0;
        run  = 0;
      end else begin
        if (medir) n_medir++;
        if (transmitir) begin
          n_tx++;
          if (tx_proibido) fail("transmitir_after_timeout");
        end
        if (pronto) begin
          n_pronto++;
          if (exp_q.size() == 0) begin
            fail("pronto_unexpected");
          end else begin
            e = exp_q.pop_front();
            check("pronto_posicao", 32'(posicao), 32'(e.pos));
            check("pronto_fim_varredura", 32'(fim_varredura), 32'(e.fim));
            check("pronto_timeout", 32'(timeout), 32'(e.to));
          end
        end else begin
          if (fim_varredura) fail("fim_varredura_without_pronto");
          if (timeout) fail("timeout_without_pronto");
        end
        if (int'(db_estado) != prev) begin
          if (prev == 1) check("posiciona_cycles", 32'(run), 32'd3);
          if (prev == 3) check("aguarda_medida_cycles", 32'(run), 32'(exp_aguarda));
          prev = int'(db_estado);
          run  = 1;
        end else begin
          run++;
        end
      end
    end
  end

  initial begin
    int base;
    int m0;
    int tx0;

    // Power-up reset state
    repeat (2) @(negedge clock);
    check("rst_estado", 32'(db_estado), 32'd0);
    check("rst_posicao", 32'(posicao), 32'd0);
    check("rst_pulses", {27'd0, medir, transmitir, pronto, fim_varredura, timeout}, 32'd0);
    reset = 1'b1;
    @(negedge clock);

    // Wrap sweep 0,1,2,3,0 then stop during ESPERA
    modo = 1'b0; med_d = 2; env_d = 4; exp_aguarda = 2;
    push(0, 0, 0); push(1, 0, 0); push(2, 0, 0); push(3, 1, 0);
    base = n_pronto;
    ligar = 1'b1;
    wait_prontos(base + 4, 400, "wrap_prontos");
    wait_estado(7, 20, "wrap_espera");
    ligar = 1'b0;
    @(negedge clock);
    check("stop_espera_estado", 32'(db_estado), 32'd0);
    check("wrap_posicao_final", 32'(posicao), 32'd0);
    m0 = n_medir;
    repeat (20) @(negedge clock);
    check("no_medir_after_stop", 32'(n_medir), 32'(m0));

    // Ping-pong sweep 0,1,2,3,2,1,0 -> 1
    modo = 1'b1;
    push(0, 0, 0); push(1, 0, 0); push(2, 0, 0); push(3, 1, 0);
    push(2, 0, 0); push(1, 0, 0); push(0, 1, 0);
    base = n_pronto;
    ligar = 1'b1;
    wait_prontos(base + 7, 600, "vaivem_prontos");
    wait_estado(7, 20, "vaivem_espera");
    ligar = 1'b0;
    @(negedge clock);
    check("vaivem_posicao_final", 32'(posicao), 32'd1);

    // Asynchronous reset while waiting for envio_pronto
    env_d = 20;
    ligar = 1'b1;
    wait_estado(5, 100, "reach_aguarda_envio");
    #1 reset = 1'b0;
    #1;
    check("async_rst_estado", 32'(db_estado), 32'd0);
    check("async_rst_posicao", 32'(posicao), 32'd0);
    ligar = 1'b0;
    @(negedge clock);
    check("rst_cycle_estado", 32'(db_estado), 32'd0);
    check("rst_cycle_pulses", {29'd0, medir, transmitir, pronto}, 32'd0);
    repeat (25) @(negedge clock);
    reset = 1'b1;
    env_d = 4;
    @(negedge clock);

    // Measurement timeout at posicao 0
    modo = 1'b0; med_d = -1; exp_aguarda = 10; tx_proibido = 1'b1;
    push(0, 0, 1);
    tx0 = n_tx;
    base = n_pronto;
    ligar = 1'b1;
    wait_prontos(base + 1, 100, "timeout_pronto");
    wait_estado(7, 20, "timeout_espera");
    ligar = 1'b0;
    tx_proibido = 1'b0;
    @(negedge clock);
    check("timeout_no_transmit", 32'(n_tx), 32'(tx0));
    check("timeout_posicao_next", 32'(posicao), 32'd1);

    // medida_pronto on the final timeout cycle wins
    med_d = 10; exp_aguarda = 10;
    push(1, 0, 0);
    tx0 = n_tx;
    base = n_pronto;
    ligar = 1'b1;
    wait_prontos(base + 1, 100, "tie_pronto");
    check("tie_transmitted", 32'(n_tx), 32'(tx0 + 1));
    wait_estado(7, 20, "tie_espera");
    ligar = 1'b0;
    @(negedge clock);
    check("tie_posicao_next", 32'(posicao), 32'd2);

    // ligar dropped in AGUARDA_MEDIDA: position completes, then INICIAL
    med_d = 2; exp_aguarda = 2;
    push(2, 0, 0);
    tx0 = n_tx;
    base = n_pronto;
    ligar = 1'b1;
    wait_estado(3, 50, "drop_reach_aguarda");
    ligar = 1'b0;
    wait_prontos(base + 1, 100, "drop_pronto");
    @(negedge clock);
    check("drop_estado_inicial", 32'(db_estado), 32'd0);
    check("drop_posicao", 32'(posicao), 32'd3);
    check("drop_transmitted", 32'(n_tx), 32'(tx0 + 1));

    repeat (5) @(negedge clock);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
